// File: rtl/branch_pkg.sv
// branch_pkg: shared FSM state type and hazard wait constants for branch resolution
package branch_pkg;
  typedef enum logic {IDLE, HOLD} br_state_t;
  localparam logic [1:0] WAIT_EX_LOAD = 2'd2;
  localparam logic [1:0] WAIT_EX_ALU = 2'd1;
  localparam logic [1:0] WAIT_MEM_LOAD = 2'd1;
endpackage

// File: rtl/branch_hazard_detect.sv
// branch_hazard_detect: stall cycles needed before a branch's rs/rt operands are available
module branch_hazard_detect
  import branch_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] i_rs,
  input  logic [REG_BITS-1:0] i_rt,
  input  logic                i_ex_reg_write,
  input  logic                i_ex_load,
  input  logic [REG_BITS-1:0] i_ex_rd,
  input  logic                i_mem_load,
  input  logic [REG_BITS-1:0] i_mem_rd,
  output logic [1:0]          o_wait
);
  logic w_ex_hit;
  logic w_mem_hit;
  always_comb begin
    w_ex_hit = i_ex_reg_write && (i_ex_rd != '0) && ((i_ex_rd == i_rs) || (i_ex_rd == i_rt));
    w_mem_hit = i_mem_load && (i_mem_rd != '0) && ((i_mem_rd == i_rs) || (i_mem_rd == i_rt));
    o_wait = w_ex_hit ? (i_ex_load ? WAIT_EX_LOAD : WAIT_EX_ALU) : w_mem_hit ? WAIT_MEM_LOAD : 2'd0;
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage BEQ/BNE resolution with hazard stall, registered redirect and statistics
module branch_resolve
  import branch_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int REG_BITS   = 5,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_id_valid,
  input  logic                  i_id_beq,
  input  logic                  i_id_bne,
  input  logic [REG_BITS-1:0]   i_id_rs,
  input  logic [REG_BITS-1:0]   i_id_rt,
  input  logic [ADDR_BITS-1:0]  i_id_target,
  input  logic                  i_equal,
  input  logic                  i_not_equal,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_load,
  input  logic [REG_BITS-1:0]   i_ex_rd,
  input  logic                  i_mem_load,
  input  logic [REG_BITS-1:0]   i_mem_rd,
  input  logic                  i_kill,
  output logic                  o_stall,
  output logic                  o_redirect_valid,
  output logic [ADDR_BITS-1:0]  o_redirect_pc,
  output logic                  o_flush_if,
  output logic [COUNT_BITS-1:0] o_branch_count,
  output logic [COUNT_BITS-1:0] o_taken_count,
  output logic                  o_cmp_error
);
  br_state_t r_state;
  logic [1:0] r_cnt;
  logic [1:0] w_wait;
  logic w_branch;
  logic w_resolve;
  logic w_bad;
  logic w_taken;
  branch_hazard_detect #(.REG_BITS(REG_BITS)) u_hazard (
    .i_rs          (i_id_rs),
    .i_rt          (i_id_rt),
    .i_ex_reg_write(i_ex_reg_write),
    .i_ex_load     (i_ex_load),
    .i_ex_rd       (i_ex_rd),
    .i_mem_load    (i_mem_load),
    .i_mem_rd      (i_mem_rd),
    .o_wait        (w_wait)
  );
  always_comb begin
    w_branch = i_id_valid && (i_id_beq || i_id_bne);
    w_resolve = !i_kill && ((r_state == IDLE) ? (w_branch && (w_wait == 2'd0)) : (r_cnt == 2'd0));
    w_bad = (i_equal == i_not_equal);
    w_taken = !w_bad && ((i_id_beq && i_equal) || (i_id_bne && i_not_equal));
    o_stall = !i_kill && ((r_state == IDLE) ? (w_branch && (w_wait != 2'd0)) : (r_cnt != 2'd0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      o_redirect_valid <= 1'b0;
      o_flush_if <= 1'b0;
      o_redirect_pc <= '0;
      o_branch_count <= '0;
      o_taken_count <= '0;
      o_cmp_error <= 1'b0;
    end else begin
      o_redirect_valid <= w_resolve && w_taken;
      o_flush_if <= w_resolve && w_taken;
      if (w_resolve && w_taken) o_redirect_pc <= i_id_target;
      if (w_resolve && !(&o_branch_count)) o_branch_count <= o_branch_count + 1'b1;
      if (w_resolve && w_taken && !(&o_taken_count)) o_taken_count <= o_taken_count + 1'b1;
      if (w_resolve && w_bad) o_cmp_error <= 1'b1;
      if (i_kill) begin
        r_state <= IDLE;
        r_cnt <= '0;
      end else if (r_state == IDLE) begin
        if (w_branch && (w_wait != 2'd0)) begin
          r_state <= HOLD;
          r_cnt <= w_wait - 2'd1;
        end
      end else if (r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed self-checking bench for branch_resolve
module tb_branch_resolve;
  localparam int AB = 32;
  localparam int RB = 5;
  localparam int CB = 4;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_beq, id_bne, equal, not_equal;
  logic [RB-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic [AB-1:0] id_target;
  logic ex_reg_write, ex_load, mem_load, kill;
  logic stall, redirect_valid, flush_if, cmp_error;
  logic [AB-1:0] redirect_pc;
  logic [CB-1:0] branch_count, taken_count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  branch_resolve #(.ADDR_BITS(AB), .REG_BITS(RB), .COUNT_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_beq(id_beq), .i_id_bne(id_bne),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_target(id_target),
    .i_equal(equal), .i_not_equal(not_equal),
    .i_ex_reg_write(ex_reg_write), .i_ex_load(ex_load), .i_ex_rd(ex_rd),
    .i_mem_load(mem_load), .i_mem_rd(mem_rd), .i_kill(kill),
    .o_stall(stall), .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_flush_if(flush_if), .o_branch_count(branch_count), .o_taken_count(taken_count),
    .o_cmp_error(cmp_error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {id_valid, id_beq, id_bne, equal, not_equal} = '0;
    {ex_reg_write, ex_load, mem_load, kill} = '0;
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0; id_target = '0;
  endtask
  task automatic br(input logic beq, input logic [RB-1:0] rs, input logic [RB-1:0] rt,
                    input logic [AB-1:0] tgt, input logic eq, input logic ne);
    id_valid = 1'b1; id_beq = beq; id_bne = !beq;
    id_rs = rs; id_rt = rt; id_target = tgt; equal = eq; not_equal = ne;
  endtask
  initial begin
    clr();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_stall", stall, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_bc", branch_count, 0);
    chk("rst_err", cmp_error, 0);
    br(1, 1, 2, 32'h10, 0, 1);
    #1 chk("nt_stall", stall, 0);
    tick(); clr();
    chk("nt_rv", redirect_valid, 0);
    chk("nt_bc", branch_count, 1);
    chk("nt_tc", taken_count, 0);
    br(0, 1, 2, 32'h40, 0, 1);
    #1 chk("tk_stall", stall, 0);
    tick(); clr();
    chk("tk_rv", redirect_valid, 1);
    chk("tk_flush", flush_if, 1);
    chk("tk_pc", redirect_pc, 32'h40);
    chk("tk_tc", taken_count, 1);
    tick();
    chk("tk_rv_off", redirect_valid, 0);
    chk("tk_flush_off", flush_if, 0);
    chk("tk_pc_hold", redirect_pc, 32'h40);
    br(1, 3, 4, 32'h80, 1, 0);
    ex_reg_write = 1; ex_load = 1; ex_rd = 3;
    #1 chk("ld_stall1", stall, 1);
    tick(); ex_reg_write = 0; ex_load = 0; ex_rd = 0;
    #1 chk("ld_stall2", stall, 1);
    tick();
    chk("ld_stall3", stall, 0);
    chk("ld_rv_early", redirect_valid, 0);
    tick(); clr();
    chk("ld_rv", redirect_valid, 1);
    chk("ld_pc", redirect_pc, 32'h80);
    chk("ld_bc", branch_count, 3);
    br(0, 6, 5, 32'h90, 1, 0);
    ex_reg_write = 1; ex_rd = 5;
    #1 chk("alu_stall1", stall, 1);
    tick(); ex_reg_write = 0; ex_rd = 0;
    #1 chk("alu_stall2", stall, 0);
    tick(); clr();
    chk("alu_rv", redirect_valid, 0);
    chk("alu_bc", branch_count, 4);
    chk("alu_tc", taken_count, 2);
    br(1, 7, 8, 32'hC0, 1, 0);
    mem_load = 1; mem_rd = 7;
    #1 chk("mem_stall1", stall, 1);
    tick(); mem_load = 0; mem_rd = 0;
    #1 chk("mem_stall2", stall, 0);
    tick(); clr();
    chk("mem_rv", redirect_valid, 1);
    chk("mem_pc", redirect_pc, 32'hC0);
    chk("mem_tc", taken_count, 3);
    tick();
    br(1, 0, 0, 32'hD0, 0, 1);
    ex_reg_write = 1; ex_load = 1; ex_rd = 0;
    #1 chk("r0_stall", stall, 0);
    tick(); clr();
    chk("r0_bc", branch_count, 6);
    br(1, 3, 4, 32'hE0, 1, 0);
    ex_reg_write = 1; ex_load = 1; ex_rd = 3;
    #1 chk("kill_stall1", stall, 1);
    tick(); ex_reg_write = 0; ex_load = 0; ex_rd = 0; kill = 1;
    #1 chk("kill_stall", stall, 0);
    tick(); clr();
    chk("kill_rv", redirect_valid, 0);
    chk("kill_bc", branch_count, 6);
    chk("kill_tc", taken_count, 3);
    br(1, 1, 2, 32'hF0, 0, 1);
    #1 chk("kill_idle", stall, 0);
    tick(); clr();
    chk("kill_bc2", branch_count, 7);
    br(1, 3, 4, 32'h100, 1, 0);
    ex_reg_write = 1; ex_load = 1; ex_rd = 3;
    #1 chk("rh_stall1", stall, 1);
    tick(); rst = 1;
    tick(); rst = 0; clr();
    #1 chk("rh_stall", stall, 0);
    chk("rh_rv", redirect_valid, 0);
    chk("rh_pc", redirect_pc, 0);
    chk("rh_bc", branch_count, 0);
    chk("rh_tc", taken_count, 0);
    br(1, 1, 2, 32'h44, 1, 1);
    tick(); clr();
    chk("bad_err", cmp_error, 1);
    chk("bad_rv", redirect_valid, 0);
    chk("bad_bc", branch_count, 1);
    chk("bad_tc", taken_count, 0);
    tick();
    chk("bad_sticky", cmp_error, 1);
    br(0, 1, 2, 32'h200, 0, 1);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_bc15", branch_count, 15);
    chk("sat_tc14", taken_count, 14);
    for (int i = 0; i < 6; i++) tick();
    clr();
    chk("sat_bc", branch_count, 15);
    chk("sat_tc", taken_count, 15);
    chk("sat_rv", redirect_valid, 1);
    chk("sat_err", cmp_error, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution controller for the ID stage. It consumes the `equal`/`not_equal` flags from the operand comparator and decides BEQ/BNE taken or not-taken. It stalls ID while a branch operand is still in flight in EX/MEM, then issues a registered one-cycle PC redirect and IF flush. It also keeps saturating branch statistics and a sticky comparator-consistency error flag.

## Interface
Parameters:
- `ADDR_BITS`, 32: width of PC / branch target.
- `REG_BITS`, 5: register-index width.
- `COUNT_BITS`, 16: width of statistics counters.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `id_valid`  input  1  ID holds a valid instruction.
- `id_beq`  input  1  instruction is BEQ.
- `id_bne`  input  1  instruction is BNE.
- `id_rs`  input  REG_BITS  first source register.
- `id_rt`  input  REG_BITS  second source register.
- `id_target`  input  ADDR_BITS  computed branch target.
- `equal`  input  1  comparator: operands equal.
- `not_equal`  input  1  comparator: operands differ.
- `ex_reg_write`  input  1  EX instruction writes a register.
- `ex_load`  input  1  EX instruction is a load.
- `ex_rd`  input  REG_BITS  EX destination register.
- `mem_load`  input  1  MEM instruction is a load.
- `mem_rd`  input  REG_BITS  MEM destination register.
- `kill`  input  1  external flush of ID (exception); aborts pending branch.
- `stall`  output  1  hold PC and IF/ID, insert bubble into EX.
- `redirect_valid`  output  1  one-cycle redirect pulse.
- `redirect_pc`  output  ADDR_BITS  target for the redirect.
- `flush_if`  output  1  squash IF/ID; same timing as `redirect_valid`.
- `branch_count`  output  COUNT_BITS  resolved branches, saturating.
- `taken_count`  output  COUNT_BITS  taken branches, saturating.
- `cmp_error`  output  1  sticky: flags seen inconsistent at resolve.

## Operation
- A branch is `id_valid & (id_beq | id_bne)`. Register 0 never matches as a hazard.
- Wait count `w`, computed from the inputs in the detect cycle:
  - `w = 2` if `ex_reg_write & ex_load` and `ex_rd` equals rs or rt.
  - `w = 1` if `ex_reg_write & !ex_load` and `ex_rd` matches.
  - `w = 1` if `mem_load` and `mem_rd` matches.
  - Otherwise `w = 0`. The EX check has priority over the MEM check.
- State IDLE:
  - Branch with `w == 0`: resolve this cycle. `taken = (id_beq & equal) | (id_bne & not_equal)`.
  - Branch with `w > 0`: `stall = 1`, load `cnt <= w-1`, go to HOLD.
  - No branch: `stall = 0`.
- State HOLD:
  - `cnt != 0`: `stall = 1`, `cnt <= cnt-1`.
  - `cnt == 0`: `stall = 0`, resolve with the current flags, return to IDLE. Hazards are not re-checked, because bubbles were inserted.
- On resolve:
  - `branch_count++`.
  - If taken: `taken_count++`, and on the next edge `redirect_valid <= 1`, `flush_if <= 1`, `redirect_pc <= id_target`.
  - If `equal == not_equal`: `cmp_error <= 1`, and the branch is resolved not-taken.
- `kill` overrides everything else:
  - `stall` and resolve are suppressed.
  - The state returns to IDLE and no redirect is produced.
  - A redirect already registered from the previous cycle still pulses.
- Counters saturate at all-ones.
- `cmp_error` clears only on `rst`.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0, `stall` = 0.
  - `redirect_valid` = 0, `flush_if` = 0, `redirect_pc` = 0.
  - both counters = 0, `cmp_error` = 0.
- `stall` is combinational from the inputs in IDLE and from state in HOLD. Total stall cycles equal `w`.
- The redirect is registered, so latency is one cycle after the resolve cycle. `redirect_valid` and `flush_if` are high for exactly one cycle. `redirect_pc` holds its value until the next taken branch.
- Back-to-back branches:
  - A branch in the cycle after a taken resolve is flushed by the pipeline. The block still evaluates it if `id_valid` is presented; an upstream flush must deassert `id_valid`.
  - The redirect from branch N and the resolve of N+1 may coincide; both complete.
- `rst` asserted mid-HOLD returns to IDLE and drops `stall` the next cycle.

## Structure
- Shared package `branch_pkg`:
  - state enum `br_state_t` {IDLE, HOLD}.
  - constants `WAIT_EX_LOAD = 2`, `WAIT_EX_ALU = 1`, `WAIT_MEM_LOAD = 1`.
- Sub-module `branch_hazard_detect`: combinational; produces `w` from the rs/rt and EX/MEM fields. It is shareable with the load-use stall logic.
- The top holds the FSM, `cnt`, the redirect registers, the counters and the error flag.

## Test plan
- **Not-taken, no hazard:** BEQ with `equal=0`, `not_equal=1`, no hazard -> `stall` never asserts, no redirect, `branch_count=1`, `taken_count=0`.
- **Taken, no hazard:** BNE, `not_equal=1`, `id_target=0x0000_0040` -> next cycle `redirect_valid=1`, `flush_if=1`, `redirect_pc=0x40` for exactly one cycle.
- **Load in EX hazard:** BEQ rs=3 with an EX load to rd=3, `equal=1` at resolve -> `stall` high 2 cycles, resolve on the 3rd cycle, redirect on the 4th.
- **ALU in EX / load in MEM hazard:** one stall cycle each. A hazard on rd=0 -> no stall.
- **Kill during HOLD:** `kill` in the first HOLD cycle -> `stall` drops, state IDLE, no redirect, counters unchanged. Also: `rst` mid-HOLD -> all outputs at reset values next cycle.
- **Inconsistent flags and saturation:** `equal=not_equal=1` at resolve -> `cmp_error` sticky 1, branch not taken. Preload counters to all-ones -> further resolves leave them at all-ones.
